// File: rtl/dft_job_ctrl_if.sv
// Wishbone B3 classic bus bundle shared by the job sequencer's slave and master ports.
interface dft_job_ctrl_if;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output adr, wdata, sel, cyc, stb, we, cti, bte,
        input  rdata, ack, err, rty
    );

    modport slave (
        input  adr, wdata, sel, cyc, stb, we, cti, bte,
        output rdata, ack, err, rty
    );
endinterface

// File: rtl/dft_job_ctrl.sv
// DFT job sequencer: a descriptor register file on a Wishbone slave port drives a
// Wishbone master that feeds the accelerator, polls it, copies results back and raises irq.
module dft_job_ctrl #(
    parameter logic [31:0] ACC_BASE     = 32'h5000_0000,
    parameter logic [31:0] ACC_IN_OFS   = 32'h0000_0000,
    parameter logic [31:0] ACC_OUT_OFS  = 32'h0000_0400,
    parameter logic [31:0] ACC_CTRL_OFS = 32'h0000_0800,
    parameter logic [31:0] ACC_STAT_OFS = 32'h0000_0804,
    parameter logic [31:0] MAX_WORDS    = 32'd256
) (
    input  logic           clk,
    input  logic           rst,
    dft_job_ctrl_if.slave  wbs,
    dft_job_ctrl_if.master wbm,
    output logic           irq
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_SRC = 3'd1,
        WR_IN  = 3'd2,
        START  = 3'd3,
        POLL   = 3'd4,
        RD_OUT = 3'd5,
        WR_DST = 3'd6,
        DONE   = 3'd7
    } state_t;

    state_t      state_r, state_nxt_s;

    logic        ack_r;
    logic [31:0] rdat_r, rd_s;
    logic        irq_en_r;
    logic [31:0] src_r, dst_r, len_r, outlen_r, limit_r;
    logic [2:0]  status_r, status_nxt_s, set_s, w1c_s;

    logic [31:0] j_src_r, j_dst_r, j_len_r, j_outlen_r, j_limit_r;
    logic [31:0] i_r, cnt_r, hold_r;
    logic [1:0]  fault_r;

    logic        cyc_r, we_r;
    logic [31:0] adr_r, wdat_r;
    logic [31:0] adr_s, dat_s;
    logic        we_s;

    logic [2:0]  idx_s;
    logic        acc_s, wr_s, go_s, len_ok_s, start_s, bad_go_s, busy_s;
    logic        bus_state_s, issue_s, xfer_ok_s, xfer_bad_s, tmo_s;
    logic        last_in_s, last_out_s;
    logic [31:0] i_inc_s, cnt_inc_s, ofs_s;
    logic        unused_s;

    assign idx_s    = wbs.adr[4:2];
    assign acc_s    = wbs.cyc & wbs.stb & ~ack_r;
    assign wr_s     = acc_s & wbs.we;
    assign go_s     = wr_s & (idx_s == 3'd0) & wbs.wdata[0];
    assign busy_s   = (state_r != IDLE);
    assign len_ok_s = (len_r != 32'd0) && (len_r <= MAX_WORDS) &&
                      (outlen_r != 32'd0) && (outlen_r <= MAX_WORDS);
    assign start_s  = go_s & ~busy_s & len_ok_s;
    assign bad_go_s = go_s & ~busy_s & ~len_ok_s;

    assign bus_state_s = (state_r != IDLE) && (state_r != DONE);
    assign issue_s     = bus_state_s & ~cyc_r;
    assign xfer_bad_s  = cyc_r & (wbm.err | wbm.rty);
    assign xfer_ok_s   = cyc_r & wbm.ack & ~(wbm.err | wbm.rty);
    assign i_inc_s     = i_r + 32'd1;
    assign cnt_inc_s   = cnt_r + 32'd1;
    assign ofs_s       = {i_r[29:0], 2'b00};
    assign last_in_s   = (i_inc_s == j_len_r);
    assign last_out_s  = (i_inc_s == j_outlen_r);
    assign tmo_s       = (j_limit_r != 32'd0) && (cnt_inc_s == j_limit_r) && ~wbm.rdata[0];

    assign unused_s = ^{wbs.sel, wbs.cti, wbs.bte, wbs.adr[31:5], wbs.adr[1:0]};

    assign wbs.ack   = ack_r;
    assign wbs.rdata = rdat_r;
    assign wbs.err   = 1'b0;
    assign wbs.rty   = 1'b0;
    assign wbm.adr   = adr_r;
    assign wbm.wdata = wdat_r;
    assign wbm.sel   = 4'hF;
    assign wbm.cyc   = cyc_r;
    assign wbm.stb   = cyc_r;
    assign wbm.we    = we_r;
    assign wbm.cti   = 3'b000;
    assign wbm.bte   = 2'b00;
    assign irq       = irq_en_r & (|status_r);

    // Register read multiplexer
    always_comb begin
        rd_s = 32'h0000_0000;
        case (idx_s)
            3'd0:    rd_s = {30'h0, irq_en_r, busy_s};
            3'd1:    rd_s = src_r;
            3'd2:    rd_s = dst_r;
            3'd3:    rd_s = len_r;
            3'd4:    rd_s = outlen_r;
            3'd5:    rd_s = {29'h0, status_r};
            3'd6:    rd_s = limit_r;
            default: rd_s = 32'h0000_0000;
        endcase
    end

    // STATUS update: sticky bits, W1C, and a set in the same cycle beats the clear
    always_comb begin
        set_s = 3'b000;
        w1c_s = 3'b000;
        if (state_r == DONE) begin
            set_s = (fault_r == 2'b00) ? 3'b001 : {fault_r[1], fault_r[0], 1'b0};
        end else begin
            set_s = 3'b000;
        end
        if (wr_s && (idx_s == 3'd5)) begin
            w1c_s = wbs.wdata[2:0];
        end else begin
            w1c_s = 3'b000;
        end
        if (start_s) begin
            status_nxt_s = 3'b000;
        end else if (bad_go_s) begin
            status_nxt_s = 3'b010;
        end else begin
            status_nxt_s = (status_r & ~w1c_s) | set_s;
        end
    end

    // Slave port: registered single-cycle ack, register writes on the ack edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r    <= 1'b0;
            rdat_r   <= 32'h0;
            irq_en_r <= 1'b0;
            src_r    <= 32'h0;
            dst_r    <= 32'h0;
            len_r    <= 32'h0;
            outlen_r <= 32'h0;
            limit_r  <= 32'h0;
            status_r <= 3'b000;
        end else begin
            ack_r    <= acc_s;
            status_r <= status_nxt_s;
            if (acc_s) begin
                rdat_r <= rd_s;
            end
            if (wr_s) begin
                case (idx_s)
                    3'd0:    irq_en_r <= wbs.wdata[1];
                    3'd1:    src_r    <= wbs.wdata;
                    3'd2:    dst_r    <= wbs.wdata;
                    3'd3:    len_r    <= wbs.wdata;
                    3'd4:    outlen_r <= wbs.wdata;
                    3'd6:    limit_r  <= wbs.wdata;
                    default: ;
                endcase
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; a bus state only advances on the ack/err of its own transfer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = start_s ? RD_SRC : IDLE;
            DONE:    state_nxt_s = IDLE;
            default: begin
                if (xfer_bad_s) begin
                    state_nxt_s = DONE;
                end else if (xfer_ok_s) begin
                    case (state_r)
                        RD_SRC:  state_nxt_s = WR_IN;
                        WR_IN:   state_nxt_s = last_in_s ? START : RD_SRC;
                        START:   state_nxt_s = POLL;
                        POLL:    state_nxt_s = wbm.rdata[0] ? RD_OUT : (tmo_s ? DONE : POLL);
                        RD_OUT:  state_nxt_s = WR_DST;
                        WR_DST:  state_nxt_s = last_out_s ? DONE : RD_OUT;
                        default: state_nxt_s = IDLE;
                    endcase
                end else begin
                    state_nxt_s = state_r;
                end
            end
        endcase
    end

    // Address, data and direction of the transfer owned by the current state
    always_comb begin
        adr_s = 32'h0;
        dat_s = 32'h0;
        we_s  = 1'b0;
        case (state_r)
            RD_SRC: adr_s = j_src_r + ofs_s;
            WR_IN: begin
                adr_s = ACC_BASE + ACC_IN_OFS + ofs_s;
                dat_s = hold_r;
                we_s  = 1'b1;
            end
            START: begin
                adr_s = ACC_BASE + ACC_CTRL_OFS;
                dat_s = 32'h0000_0001;
                we_s  = 1'b1;
            end
            POLL:   adr_s = ACC_BASE + ACC_STAT_OFS;
            RD_OUT: adr_s = ACC_BASE + ACC_OUT_OFS + ofs_s;
            WR_DST: begin
                adr_s = j_dst_r + ofs_s;
                dat_s = hold_r;
                we_s  = 1'b1;
            end
            default: begin
                adr_s = 32'h0;
                dat_s = 32'h0;
                we_s  = 1'b0;
            end
        endcase
    end

    // Master port: raise cyc/stb the cycle after state entry, drop the cycle after ack/err
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_r  <= 1'b0;
            we_r   <= 1'b0;
            adr_r  <= 32'h0;
            wdat_r <= 32'h0;
        end else if (xfer_ok_s || xfer_bad_s) begin
            cyc_r <= 1'b0;
        end else if (issue_s) begin
            cyc_r  <= 1'b1;
            we_r   <= we_s;
            adr_r  <= adr_s;
            wdat_r <= dat_s;
        end
    end

    // Job datapath: descriptor snapshot, word index, poll count, hold register, fault kind
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j_src_r    <= 32'h0;
            j_dst_r    <= 32'h0;
            j_len_r    <= 32'h0;
            j_outlen_r <= 32'h0;
            j_limit_r  <= 32'h0;
            i_r        <= 32'h0;
            cnt_r      <= 32'h0;
            hold_r     <= 32'h0;
            fault_r    <= 2'b00;
        end else if (start_s) begin
            j_src_r    <= src_r;
            j_dst_r    <= dst_r;
            j_len_r    <= len_r;
            j_outlen_r <= outlen_r;
            j_limit_r  <= limit_r;
            i_r        <= 32'h0;
            cnt_r      <= 32'h0;
            fault_r    <= 2'b00;
        end else if (xfer_bad_s) begin
            fault_r <= 2'b01;
        end else if (xfer_ok_s) begin
            case (state_r)
                RD_SRC, RD_OUT: hold_r <= wbm.rdata;
                WR_IN:          i_r    <= last_in_s ? 32'h0 : i_inc_s;
                WR_DST:         i_r    <= i_inc_s;
                POLL: begin
                    if (!wbm.rdata[0]) begin
                        cnt_r <= cnt_inc_s;
                    end
                    if (tmo_s) begin
                        fault_r <= 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dft_job_ctrl.sv
// Scoreboard bench for dft_job_ctrl: directed jobs push expected master transfers and
// register reads; a monitor pops and compares as the DUT presents them.
module tb_dft_job_ctrl;

    localparam logic [31:0] ACC  = 32'h5000_0000;
    localparam logic [31:0] OUTW = 32'h5000_0400;
    localparam logic [31:0] CTRL = 32'h5000_0800;
    localparam logic [31:0] STAT = 32'h5000_0804;
    localparam logic [31:0] SRC  = 32'h0000_1000;
    localparam logic [31:0] DST  = 32'h0000_8000;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } xfer_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;

    dft_job_ctrl_if wbs ();
    dft_job_ctrl_if wbm ();

    dft_job_ctrl dut (.clk(clk), .rst(rst), .wbs(wbs), .wbm(wbm), .irq(irq));

    always #5 clk = ~clk;

    xfer_t       exp_q[$];
    logic [31:0] rd_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          wait_cfg = 0, wait_ctr = 0, poll_seen = 0, xfer_seen = 0;
    int          done_at = 0, err_at = 0;
    bit          cyc_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a[31:12] == 20'h50000 && a[11:10] == 2'b01) return 32'hC0DE_0000 | {24'h0, a[9:2]};
        else if (a[15:12] == 4'h1) return {24'h0, a[9:2]} + 32'd1;
        else return {4'hA, a[15:12], 16'h0, a[9:2]};
    endfunction

    // Bus-side memory / accelerator model, drives responses on the falling edge
    initial begin
        wbm.ack = 1'b0; wbm.err = 1'b0; wbm.rty = 1'b0; wbm.rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (wbm.ack || wbm.err || wbm.rty || rst) begin
                wbm.ack = 1'b0; wbm.err = 1'b0; wbm.rty = 1'b0; wait_ctr = 0;
            end else if (wbm.cyc && wbm.stb) begin
                if (wait_ctr < wait_cfg) begin
                    wait_ctr++;
                end else begin
                    wait_ctr = 0;
                    xfer_seen++;
                    if (xfer_seen == err_at) begin
                        wbm.err = 1'b1;
                    end else begin
                        wbm.ack = 1'b1;
                        if (wbm.adr == STAT && !wbm.we) begin
                            poll_seen++;
                            wbm.rdata = (poll_seen == done_at) ? 32'h1 : 32'h0;
                        end else begin
                            wbm.rdata = mem_rd(wbm.adr);
                        end
                    end
                end
            end
        end
    end

    // Monitor: compares every completed master transfer and slave read against the queues
    initial begin : mon
        xfer_t       e;
        logic [31:0] er;
        forever begin
            @(negedge clk);
            #2;
            if (wbm.cyc) cyc_seen = 1'b1;
            if (wbm.cyc && wbm.stb && (wbm.ack || wbm.err || wbm.rty)) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL xfer_unexpected: got adr %h we %b dat %h, expected no transfer",
                             wbm.adr, wbm.we, wbm.wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (wbm.adr !== e.adr || wbm.we !== e.we || (e.we && wbm.wdata !== e.dat)) begin
                        n_fail++;
                        $display("FAIL xfer: got adr %h we %b dat %h, expected adr %h we %b dat %h",
                                 wbm.adr, wbm.we, wbm.wdata, e.adr, e.we, e.dat);
                    end
                end
            end
            if (wbs.cyc && wbs.stb && !wbs.we && wbs.ack) begin
                if (rd_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL reg_read_unexpected: got %h, expected no read", wbs.rdata);
                end else begin
                    er = rd_q.pop_front();
                    chk("reg_read", wbs.rdata, er);
                end
            end
        end
    end

    task automatic wb_acc(input logic [2:0] idx, input logic we, input logic [31:0] d);
        int t;
        t = 0;
        @(negedge clk);
        wbs.adr = {27'h0, idx, 2'b00}; wbs.wdata = d; wbs.we = we;
        wbs.cyc = 1'b1; wbs.stb = 1'b1;
        do begin
            @(negedge clk);
            #3;
            t++;
        end while (!wbs.ack && t < 20);
        if (!wbs.ack) begin
            n_chk++;
            n_fail++;
            $display("FAIL slave_ack: no ack after %0d cycles, required within 20", t);
        end
        wbs.cyc = 1'b0; wbs.stb = 1'b0;
    endtask

    task automatic wr_reg(input logic [2:0] idx, input logic [31:0] d);
        wb_acc(idx, 1'b1, d);
    endtask

    task automatic rd_reg(input logic [2:0] idx, input logic [31:0] exp);
        rd_q.push_back(exp);
        wb_acc(idx, 1'b0, 32'h0);
    endtask

    task automatic wait_irq(input string nm);
        int t;
        for (t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (irq) break;
        end
        if (!irq) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_irq_wait: irq still 0 after %0d cycles, expected 1", nm, t);
        end
    endtask

    // Expected master traffic for one job; err_at truncates at the faulting transfer
    task automatic build_exp(input logic [31:0] src, dst, len, outlen, limit, input int d_at, e_at);
        xfer_t l[$];
        bit    tmo, inf;
        int    np, n;
        tmo = (limit != 32'd0) && (d_at == 0 || d_at > int'(limit));
        inf = (limit == 32'd0) && (d_at == 0);
        np  = tmo ? int'(limit) : (inf ? 40 : d_at);
        for (int k = 0; k < int'(len); k++) begin
            l.push_back('{1'b0, src + 32'(k * 4), 32'h0});
            l.push_back('{1'b1, ACC + 32'(k * 4), mem_rd(src + 32'(k * 4))});
        end
        l.push_back('{1'b1, CTRL, 32'h1});
        for (int p = 0; p < np; p++) l.push_back('{1'b0, STAT, 32'h0});
        if (!tmo && !inf) begin
            for (int k = 0; k < int'(outlen); k++) begin
                l.push_back('{1'b0, OUTW + 32'(k * 4), 32'h0});
                l.push_back('{1'b1, dst + 32'(k * 4), mem_rd(OUTW + 32'(k * 4))});
            end
        end
        n = (e_at != 0) ? e_at : l.size();
        for (int j = 0; j < n; j++) exp_q.push_back(l[j]);
    endtask

    task automatic setup(input logic [31:0] src, dst, len, outlen, limit, input int d_at, e_at, w);
        wait_cfg = w; done_at = d_at; err_at = e_at; poll_seen = 0; xfer_seen = 0;
        wr_reg(3'd1, src); wr_reg(3'd2, dst); wr_reg(3'd3, len);
        wr_reg(3'd4, outlen); wr_reg(3'd6, limit);
        if (len != 32'd0 && len <= 32'd256 && outlen != 32'd0 && outlen <= 32'd256)
            build_exp(src, dst, len, outlen, limit, d_at, e_at);
        cyc_seen = 1'b0;
    endtask

    task automatic run_job(input string nm, input logic [31:0] src, dst, len, outlen, limit,
                           input int d_at, e_at, w, input logic [2:0] exp_st);
        bit legal;
        legal = (len != 32'd0 && len <= 32'd256 && outlen != 32'd0 && outlen <= 32'd256);
        setup(src, dst, len, outlen, limit, d_at, e_at, w);
        wr_reg(3'd0, 32'h3);
        wait_irq(nm);
        repeat (3) @(negedge clk);
        chk({nm, "_exp_left"}, exp_q.size(), 32'd0);
        chk({nm, "_cyc_seen"}, {31'h0, cyc_seen}, {31'h0, legal});
        chk({nm, "_irq_set"}, {31'h0, irq}, 32'h1);
        rd_reg(3'd5, {29'h0, exp_st});
        rd_reg(3'd0, 32'h2);
        wr_reg(3'd5, 32'h7);
        chk({nm, "_irq_clr"}, {31'h0, irq}, 32'h0);
    endtask

    initial begin : main
        int t;
        wbs.adr = 32'h0; wbs.wdata = 32'h0; wbs.sel = 4'hF; wbs.cyc = 1'b0;
        wbs.stb = 1'b0; wbs.we = 1'b0; wbs.cti = 3'b000; wbs.bte = 2'b00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cyc", {31'h0, wbm.cyc}, 32'h0);
        chk("rst_stb", {31'h0, wbm.stb}, 32'h0);
        chk("rst_adr", wbm.adr, 32'h0);
        chk("rst_sel", {28'h0, wbm.sel}, 32'hF);
        chk("rst_cti_bte", {27'h0, wbm.cti, wbm.bte}, 32'h0);
        chk("rst_irq_ack", {30'h0, irq, wbs.ack}, 32'h0);
        rst = 1'b0;

        run_job("job4", SRC, DST, 32'd4, 32'd4, 32'd0, 3, 0, 0, 3'b001);
        run_job("err",  SRC, DST, 32'd4, 32'd4, 32'd0, 3, 4, 1, 3'b010);
        run_job("tmo",  SRC, DST, 32'd1, 32'd1, 32'd5, 0, 0, 2, 3'b100);
        run_job("len0", SRC, DST, 32'd0, 32'd4, 32'd0, 3, 0, 0, 3'b010);
        run_job("len257", SRC, DST, 32'd257, 32'd4, 32'd0, 3, 0, 0, 3'b010);

        // Second go and SRC rewrite while busy
        setup(SRC, DST, 32'd2, 32'd1, 32'd0, 1, 0, 3);
        wr_reg(3'd0, 32'h3);
        wr_reg(3'd1, 32'h0000_3000);
        wr_reg(3'd0, 32'h3);
        rd_reg(3'd0, 32'h3);
        rd_reg(3'd1, 32'h0000_3000);
        rd_reg(3'd0, 32'h3);
        wait_irq("midgo");
        repeat (3) @(negedge clk);
        chk("midgo_exp_left", exp_q.size(), 32'd0);
        rd_reg(3'd5, 32'h1);
        wr_reg(3'd5, 32'h7);

        // Reset while a poll is on the bus
        setup(SRC, DST, 32'd1, 32'd1, 32'd0, 0, 0, 1);
        wr_reg(3'd0, 32'h3);
        for (t = 0; t < 500; t++) begin
            @(negedge clk);
            #1;
            if (wbm.cyc && wbm.adr == STAT) break;
        end
        chk("rstjob_poll_seen", {31'h0, wbm.cyc}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstjob_cyc_drop", {30'h0, wbm.cyc, wbm.stb}, 32'h0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 8; r++) rd_reg(3'(r), 32'h0);
        chk("rstjob_irq", {31'h0, irq}, 32'h0);
        run_job("fresh", SRC, DST, 32'd4, 32'd4, 32'd0, 3, 0, 1, 3'b001);

        repeat (4) @(negedge clk);
        chk("rd_q_left", rd_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dft_job_ctrl.md
# dft_job_ctrl

Job sequencer for the DFT accelerator slave on a compute tile's Wishbone B3 bus. Software programs a descriptor through a small Wishbone slave register file. The block then runs the whole job as a Wishbone master with no further CPU involvement:
- copies input words from a source buffer into the accelerator input window,
- starts the accelerator and polls its status register,
- copies the results to a destination buffer,
- raises an interrupt.

It sits on the same bus as the network adapter and accelerator, using one master port and one slave port.

## Interface
- ACC_BASE, 32'h5000_0000, accelerator base address
- ACC_IN_OFS, 32'h0000, offset of accelerator input window
- ACC_OUT_OFS, 32'h0400, offset of accelerator output window
- ACC_CTRL_OFS, 32'h0800, accelerator control register; bit0 = start
- ACC_STAT_OFS, 32'h0804, accelerator status register; bit0 = done
- MAX_WORDS, 256, largest legal LEN/OUTLEN
- clk  in  1  bus clock
- rst  in  1  reset, asynchronous, active-high
- wbs_adr_i  in  32  slave address; only [4:2] decoded
- wbs_dat_i  in  32  slave write data
- wbs_sel_i  in  4  byte selects; ignored, full-word access only
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  slave cycle / strobe / write enable
- wbs_dat_o  out  32  slave read data
- wbs_ack_o  out  1  slave acknowledge
- wbs_err_o, wbs_rty_o  out  1 each  tied 0
- wbm_adr_o  out  32  master address
- wbm_dat_o  out  32  master write data
- wbm_sel_o  out  4  constant 4'hF
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  master cycle / strobe / write enable
- wbm_cti_o  out  3  constant 3'b000 (classic)
- wbm_bte_o  out  2  constant 2'b00
- wbm_dat_i  in  32  master read data
- wbm_ack_i, wbm_err_i, wbm_rty_i  in  1 each  master ack / error / retry
- irq  out  1  level interrupt = irq_en & (done | err)

## Operation
Register map (index = wbs_adr_i[4:2]):
- 0 CTRL
  - write: bit0 = go (self-clearing pulse), bit1 = irq_en
  - read: {30'b0, irq_en, busy}
- 1 SRC: source byte address, word aligned.
- 2 DST: destination byte address, word aligned.
- 3 LEN: input word count.
- 4 OUTLEN: output word count.
- 5 STATUS: bit0 done, bit1 bus_err, bit2 timeout. Sticky; write-1-to-clear.
- 6 POLL_LIMIT: maximum number of status polls; 0 = unlimited.
- Indices 7 and unused bits read 0.

Go handling:
- Ignored while busy.
- LEN or OUTLEN equal to 0 or greater than MAX_WORDS → go sets bus_err and raises irq; no master traffic is issued.
- Descriptor registers may be written while busy. The active job uses the values latched at go.

State machine:
- IDLE → RD_SRC on a legal go. Latch descriptor; word index i = 0; STATUS bits cleared.
- RD_SRC: read SRC+4i into the hold register.
- WR_IN: write the hold register to ACC_BASE+ACC_IN_OFS+4i. i++. If i == LEN → START (i reset to 0), else → RD_SRC.
- START: write 32'h1 to ACC_BASE+ACC_CTRL_OFS → POLL.
- POLL: read ACC_BASE+ACC_STAT_OFS.
  - bit0 = 1 → RD_OUT.
  - Otherwise poll count++. If POLL_LIMIT ≠ 0 and count == POLL_LIMIT → DONE with timeout = 1.
- RD_OUT: read ACC_BASE+ACC_OUT_OFS+4i.
- WR_DST: write to DST+4i. i++. If i == OUTLEN → DONE.
- DONE: set done (or the fault bit) → IDLE.

Error handling:
- wbm_err_i in any master state → DONE with bus_err = 1; done is not set.
- wbm_rty_i is treated identically to wbm_err_i.

Arithmetic:
- Address arithmetic is 32-bit modulo; wrap past 32'hFFFF_FFFC is not flagged.
- i and the poll count are 32-bit counters.

## Timing
- Reset values:
  - Every output is 0, except constants: wbm_sel_o = 4'hF, wbm_cti_o = 0, wbm_bte_o = 0.
  - All registers are 0 and state = IDLE.
- Asserting rst mid-job drops wbm_cyc_o/wbm_stb_o immediately (combinationally from reset flops) and abandons the job.
- Master port:
  - cyc and stb are asserted together in the cycle after state entry.
  - Address, data and we are held stable until ack or err is sampled.
  - cyc and stb drop in the cycle after ack. One idle cycle separates successive transfers.
  - Each transfer therefore costs at least 2 + (slave wait states) cycles.
- Read data is captured on the same edge that samples wbm_ack_i.
- Slave port:
  - wbs_ack_o is registered: asserted one cycle after cyc & stb, for exactly one cycle.
  - No back-to-back ack; stb must be seen again after ack falls.
  - Writes take effect on the ack edge.
- Go while in IDLE: busy reads 1 from the cycle after the go ack.
- A STATUS W1C write in the same cycle the FSM sets a bit: the set wins.
- irq asserts in the cycle after DONE and holds until STATUS is cleared or irq_en is cleared.

## Test plan
- LEN=4, OUTLEN=4, SRC data 1,2,3,4, accelerator model asserts done on the 3rd poll:
  - exactly 4 reads, 4 writes to ACC_BASE+0..C, 1 start write, 3 polls, 4 output copies to DST;
  - STATUS=1; irq=1 when irq_en=1.
- wbm_err_i on the 2nd WR_IN → STATUS=3'b010, done=0, no START write, busy=0, irq=1.
- POLL_LIMIT=5, done never set → exactly 5 polls, STATUS=3'b100, no RD_OUT traffic.
- LEN=0 go, and LEN=MAX_WORDS+1 go → STATUS=3'b010 immediately, wbm_cyc_o never asserted.
- Second go and SRC rewrite mid-job → ignored; active job still uses the original SRC; busy reads 1 throughout.
- rst asserted during POLL with wbm_cyc_o=1 → cyc drops in the same cycle; all registers read 0 after reset; a fresh job completes normally.
